// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA stream types and constants for the game-over compositing stage
package vga_pkg;

  localparam int unsigned HOR_TOTAL = 1344;
  localparam int unsigned VER_TOTAL = 806;

  // Counter width sized to the larger of the two raster totals
  localparam int unsigned CNT_W = $clog2((HOR_TOTAL > VER_TOTAL) ? HOR_TOTAL : VER_TOTAL);

  typedef logic [11:0] rgb_t;

  typedef enum logic [1:0] {
    HIDDEN = 2'd0,
    FADE   = 2'd1,
    SHOWN  = 2'd2
  } mix_state_t;

  // One pixel of a VGA stream: timing fields plus colour
  typedef struct packed {
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic             hsync;
    logic             vsync;
    logic             hblnk;
    logic             vblnk;
    rgb_t             rgb;
  } vga_t;

endpackage

// File: rtl/rgb_blend.sv
// rtl/rgb_blend.sv - combinational per-channel alpha blend of overlay onto background
module rgb_blend
  import vga_pkg::*;
(
  input  rgb_t       ov,
  input  rgb_t       bg,
  input  logic [4:0] ea,
  output rgb_t       rgb
);

  // Background weight; ea never exceeds 16 so this cannot wrap
  logic [4:0] ea_inv;
  assign ea_inv = 5'd16 - ea;

  // Each channel: (ov*ea + bg*(16-ea)) >> 4; the sum tops out at 240 so 8 bits suffice
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [7:0] sum;
    assign sum = ({4'd0, ov[4*c +: 4]} * {3'd0, ea}) + ({4'd0, bg[4*c +: 4]} * {3'd0, ea_inv});
    assign rgb[4*c +: 4] = 4'(sum >> 4);
  end

endmodule

// File: rtl/gameover_mixer.sv
// rtl/gameover_mixer.sv - fades/blinks the game-over overlay onto the VGA stream; GAMEOVER_BLINK_EN enables blinking
module gameover_mixer
  import vga_pkg::*;
#(
  parameter int unsigned FADE_FRAMES  = 2,
  parameter int unsigned BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst,
  input  vga_t vin,
  input  rgb_t ov_rgb,
  input  logic ov_valid,
  input  logic game_over,
  input  logic restart,
  output vga_t vout,
  output logic shown
);

  localparam logic [7:0] FADE_LAST  = 8'(FADE_FRAMES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  vga_t       vin_a_q;
  vga_t       vout_q, vout_d;
  mix_state_t state_q, state_d;
  logic [4:0] alpha_q, alpha_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       blink_on_q, blink_on_d;
  logic       go_prev_q;

  logic       frame_tick;
  logic       go_rise;
  logic [7:0] cnt_last;
  logic       cnt_hit;
  logic [4:0] ea;
  rgb_t       blend_rgb;

  assign frame_tick = (vin_a_q.hcount == '0) && (vin_a_q.vcount == '0);
  assign go_rise    = game_over & ~go_prev_q;
  assign cnt_last   = (state_q == SHOWN) ? BLINK_LAST : FADE_LAST;
  assign cnt_hit    = (frame_cnt_q == cnt_last);
  assign ea         = (ov_valid && (blink_on_q || state_q == FADE)) ? alpha_q : 5'd0;
  assign shown      = (state_q == SHOWN);
  assign vout       = vout_q;

  rgb_blend u_blend (
    .ov  (ov_rgb),
    .bg  (vin_a_q.rgb),
    .ea  (ea),
    .rgb (blend_rgb)
  );

  // Stage B contents: stage-A timing, blended colour, black during blanking
  always_comb begin
    vout_d     = vin_a_q;
    vout_d.rgb = (vin_a_q.hblnk | vin_a_q.vblnk) ? 12'h000 : blend_rgb;
  end

  // Two-stage pipeline: stage A lines vin up with the overlay, stage B holds the output
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vin_a_q <= '0;
      vout_q  <= '0;
    end else begin
      vin_a_q <= vin;
      vout_q  <= vout_d;
    end
  end

  // Overlay state machine; restart overrides everything else
  always_comb begin
    state_d     = state_q;
    alpha_d     = alpha_q;
    frame_cnt_d = frame_cnt_q;
    blink_on_d  = blink_on_q;
    if (restart) begin
      state_d     = HIDDEN;
      alpha_d     = 5'd0;
      frame_cnt_d = 8'd0;
      blink_on_d  = 1'b0;
    end else begin
      case (state_q)
        HIDDEN: begin
          alpha_d    = 5'd0;
          blink_on_d = 1'b0;
          if (go_rise) begin
            state_d     = FADE;
            frame_cnt_d = 8'd0;
          end
        end
        FADE: begin
          if (frame_tick) begin
            if (cnt_hit) begin
              frame_cnt_d = 8'd0;
              alpha_d     = alpha_q + 5'd1;
              if (alpha_q == 5'd15) begin
                state_d    = SHOWN;
                blink_on_d = 1'b1;
              end
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
        end
        SHOWN: begin
          alpha_d = 5'd16;
`ifdef GAMEOVER_BLINK_EN
          if (frame_tick) begin
            if (cnt_hit) begin
              blink_on_d  = ~blink_on_q;
              frame_cnt_d = 8'd0;
            end else begin
              frame_cnt_d = frame_cnt_q + 8'd1;
            end
          end
`else
          blink_on_d = 1'b1;
`endif
        end
        default: begin
          state_d     = HIDDEN;
          alpha_d     = 5'd0;
          frame_cnt_d = 8'd0;
          blink_on_d  = 1'b0;
        end
      endcase
    end
  end

  // FSM, fade/blink counters and game_over edge register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HIDDEN;
      alpha_q     <= 5'd0;
      frame_cnt_q <= 8'd0;
      blink_on_q  <= 1'b0;
      go_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      alpha_q     <= alpha_d;
      frame_cnt_q <= frame_cnt_d;
      blink_on_q  <= blink_on_d;
      go_prev_q   <= game_over;
    end
  end

endmodule
